// File: rtl/lc4_retire_unit.sv
// In-order retirement at the ROB head: keeps the retirement RAT, frees superseded
// physical registers, and on a mispredict flushes then replays the RRAT into rename.

module lc4_decoder (
   input  logic [15:0] i_insn,
   output logic [2:0]  o_wsel,
   output logic        o_regfile_we
);
   logic w_unused;

   assign w_unused = ^i_insn[8:0];

   // JSR/JSRR and TRAP link through R7; everything else that writes uses Rd
   always_comb begin
      o_wsel       = i_insn[11:9];
      o_regfile_we = 1'b0;
      case (i_insn[15:12])
         4'h1, 4'h5, 4'h6, 4'h9, 4'hA, 4'hD: o_regfile_we = 1'b1;
         4'h4, 4'hF: begin
            o_regfile_we = 1'b1;
            o_wsel       = 3'd7;
         end
         default: ;
      endcase
   end
endmodule

module lc4_retire_unit #(
   parameter int NUM_AREGS = 8,
   parameter int PREG_W    = 4,
   parameter int CNT_W     = 16
) (
   input  logic              i_clk,
   input  logic              i_rst_n,
   input  logic              i_gwe,
   input  logic              i_cm_ready,
   input  logic [15:0]       i_cm_insn,
   input  logic [15:0]       i_cm_pc,
   input  logic [15:0]       i_cm_pc_pred,
   input  logic [15:0]       i_cm_pc_redirect,
   input  logic [PREG_W-1:0] i_cm_prdsel,
   input  logic [PREG_W-1:0] i_cm_pprdsel,
   output logic              o_rob_deq,
   output logic              o_free_valid,
   output logic [PREG_W-1:0] o_free_preg,
   output logic              o_flush,
   output logic [15:0]       o_redirect_pc,
   output logic              o_fetch_stall,
   output logic              o_restore_valid,
   output logic [2:0]        o_restore_areg,
   output logic [PREG_W-1:0] o_restore_preg,
   output logic [CNT_W-1:0]  o_retire_count
);
   localparam logic [2:0] LAST_IDX = 3'(NUM_AREGS - 1);

   typedef enum logic [1:0] {
      ST_RUN,
      ST_FLUSH,
      ST_RESTORE
   } state_t;

   state_t              r_state;
   state_t              w_state_next;
   logic [PREG_W-1:0]   r_rrat [NUM_AREGS];
   logic [2:0]          r_idx;
   logic [CNT_W-1:0]    r_retire_count;
   logic [15:0]         r_redirect_pc;

   logic [2:0]          w_wsel;
   logic                w_regfile_we;
   logic                w_retire;
   logic                w_mispredict;
   logic                w_free;
   logic                w_unused;

   assign w_unused = ^i_cm_pc;

   lc4_decoder u_dec (
      .i_insn       (i_cm_insn),
      .o_wsel       (w_wsel),
      .o_regfile_we (w_regfile_we)
   );

   assign w_retire     = i_gwe & i_cm_ready & (r_state == ST_RUN);
   assign w_mispredict = w_retire & (i_cm_pc_redirect != i_cm_pc_pred);
   assign w_free       = w_retire & w_regfile_we;

   assign o_free_valid   = w_free;
   assign o_free_preg    = w_free ? i_cm_pprdsel : '0;
   assign o_redirect_pc  = r_redirect_pc;
   assign o_restore_areg = r_idx;
   assign o_restore_preg = r_rrat[r_idx];
   assign o_retire_count = r_retire_count;

   always_ff @(posedge i_clk or negedge i_rst_n) begin
      if (!i_rst_n) begin
         r_state <= ST_RUN;
      end else begin
         r_state <= w_state_next;
      end
   end

   always_comb begin
      w_state_next    = r_state;
      o_rob_deq       = 1'b0;
      o_flush         = 1'b0;
      o_restore_valid = 1'b0;
      o_fetch_stall   = 1'b0;
      case (r_state)
         ST_RUN: begin
            o_rob_deq = w_retire;
            if (w_mispredict) w_state_next = ST_FLUSH;
         end
         ST_FLUSH: begin
            o_flush       = i_gwe;
            o_fetch_stall = 1'b1;
            if (i_gwe) w_state_next = ST_RESTORE;
         end
         ST_RESTORE: begin
            o_restore_valid = i_gwe;
            o_fetch_stall   = 1'b1;
            if (i_gwe && r_idx == LAST_IDX) w_state_next = ST_RUN;
         end
         default: w_state_next = ST_RUN;
      endcase
   end

   always_ff @(posedge i_clk or negedge i_rst_n) begin
      if (!i_rst_n) begin
         r_retire_count <= '0;
         r_redirect_pc  <= '0;
         r_idx          <= '0;
      end else begin
         if (w_retire) r_retire_count <= r_retire_count + 1'b1;
         if (w_mispredict) r_redirect_pc <= i_cm_pc_redirect;
         if (i_gwe && r_state == ST_RESTORE) begin
            r_idx <= (r_idx == LAST_IDX) ? 3'd0 : r_idx + 3'd1;
         end
      end
   end

   // One register per architectural entry so each resets to its own identity mapping
   generate
      for (genvar gi = 0; gi < NUM_AREGS; gi++) begin : g_rrat
         always_ff @(posedge i_clk or negedge i_rst_n) begin
            if (!i_rst_n) begin
               r_rrat[gi] <= PREG_W'(gi);
            end else if (w_free && w_wsel == 3'(gi)) begin
               r_rrat[gi] <= i_cm_prdsel;
            end
         end
      end
   endgenerate
endmodule

// File: tb/tb_lc4_retire_unit.sv
// Directed bench for lc4_retire_unit: a recovery-countdown model checked every cycle
// plus hand-computed expectations at the key points of each scenario.

module tb_lc4_retire_unit;
   logic        clk = 1'b0;
   logic        rst_n;
   logic        gwe;
   logic        cm_ready;
   logic [15:0] cm_insn;
   logic [15:0] cm_pc;
   logic [15:0] cm_pc_pred;
   logic [15:0] cm_pc_redirect;
   logic [3:0]  cm_prdsel;
   logic [3:0]  cm_pprdsel;
   logic        rob_deq;
   logic        free_valid;
   logic [3:0]  free_preg;
   logic        flush;
   logic [15:0] redirect_pc;
   logic        fetch_stall;
   logic        restore_valid;
   logic [2:0]  restore_areg;
   logic [3:0]  restore_preg;
   logic [15:0] retire_count;

   int n_checks = 0;
   int n_errors = 0;

   // model: phase 0 = running, 1 = flush cycle, 2..9 = restore of areg (phase-2)
   int          m_phase;
   logic [3:0]  m_rrat [8];
   logic [15:0] m_count;
   logic [15:0] m_rpc;

   always #5 clk = ~clk;

   lc4_retire_unit dut (
      .i_clk            (clk),
      .i_rst_n          (rst_n),
      .i_gwe            (gwe),
      .i_cm_ready       (cm_ready),
      .i_cm_insn        (cm_insn),
      .i_cm_pc          (cm_pc),
      .i_cm_pc_pred     (cm_pc_pred),
      .i_cm_pc_redirect (cm_pc_redirect),
      .i_cm_prdsel      (cm_prdsel),
      .i_cm_pprdsel     (cm_pprdsel),
      .o_rob_deq        (rob_deq),
      .o_free_valid     (free_valid),
      .o_free_preg      (free_preg),
      .o_flush          (flush),
      .o_redirect_pc    (redirect_pc),
      .o_fetch_stall    (fetch_stall),
      .o_restore_valid  (restore_valid),
      .o_restore_areg   (restore_areg),
      .o_restore_preg   (restore_preg),
      .o_retire_count   (retire_count)
   );

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_errors++;
         $display("FAIL %s actual=%h required=%h at %0t", name, act, exp, $time);
      end
   endtask

   function automatic bit writes_reg(input logic [15:0] insn, output logic [2:0] rd);
      int opc;
      opc = int'(insn[15:12]);
      rd  = (opc == 4 || opc == 15) ? 3'd7 : insn[11:9];
      return opc inside {1, 4, 5, 6, 9, 10, 13, 15};
   endfunction

   task automatic model_reset();
      m_phase = 0;
      m_count = 16'h0;
      m_rpc   = 16'h0;
      for (int i = 0; i < 8; i++) m_rrat[i] = 4'(i);
   endtask

   initial model_reset();

   always @(negedge clk) begin
      logic        e_deq, e_free, e_flush, e_stall, e_rv, we;
      logic [3:0]  e_fpreg, e_rpreg;
      logic [2:0]  e_areg, rd;
      if (!rst_n) begin
         e_deq = 0; e_free = 0; e_fpreg = 0; e_flush = 0; e_stall = 0; e_rv = 0;
         e_areg = 0; e_rpreg = 0;
         check("m_count_rst", 32'(retire_count), 32'h0);
         check("m_rpc_rst", 32'(redirect_pc), 32'h0);
         model_reset();
      end else begin
         we      = writes_reg(cm_insn, rd);
         e_deq   = (m_phase == 0) && gwe && cm_ready;
         e_free  = e_deq && we;
         e_fpreg = e_free ? cm_pprdsel : 4'h0;
         e_flush = (m_phase == 1) && gwe;
         e_stall = (m_phase != 0);
         e_rv    = (m_phase >= 2) && gwe;
         e_areg  = (m_phase >= 2) ? 3'(m_phase - 2) : 3'd0;
         e_rpreg = m_rrat[e_areg];
         check("m_count", 32'(retire_count), 32'(m_count));
         check("m_rpc", 32'(redirect_pc), 32'(m_rpc));
         if (gwe) begin
            if (e_deq) begin
               m_count = m_count + 16'd1;
               if (we) m_rrat[rd] = cm_prdsel;
               if (cm_pc_redirect != cm_pc_pred) begin
                  m_rpc   = cm_pc_redirect;
                  m_phase = 1;
               end
            end else if (m_phase >= 1) begin
               m_phase = (m_phase == 9) ? 0 : m_phase + 1;
            end
         end
      end
      check("m_rob_deq", 32'(rob_deq), 32'(e_deq));
      check("m_free_valid", 32'(free_valid), 32'(e_free));
      check("m_free_preg", 32'(free_preg), 32'(e_fpreg));
      check("m_flush", 32'(flush), 32'(e_flush));
      check("m_fetch_stall", 32'(fetch_stall), 32'(e_stall));
      check("m_restore_valid", 32'(restore_valid), 32'(e_rv));
      check("m_restore_areg", 32'(restore_areg), 32'(e_areg));
      check("m_restore_preg", 32'(restore_preg), 32'(e_rpreg));
   end

   task automatic to_neg();
      @(negedge clk); #1;
   endtask

   task automatic to_pos();
      @(posedge clk); #1;
   endtask

   task automatic head(input logic [15:0] insn, input logic [15:0] pc, input logic [15:0] pred,
                       input logic [15:0] redir, input logic [3:0] prd, input logic [3:0] pprd);
      cm_ready = 1'b1; cm_insn = insn; cm_pc = pc; cm_pc_pred = pred;
      cm_pc_redirect = redir; cm_prdsel = prd; cm_pprdsel = pprd;
      $display("txn insn=%h pc=%h pred=%h redir=%h prd=%0d pprd=%0d", insn, pc, pred, redir, prd, pprd);
   endtask

   initial begin
      rst_n = 1'b0; gwe = 1'b1; cm_ready = 1'b0; cm_insn = 16'h0; cm_pc = 16'h0;
      cm_pc_pred = 16'h0; cm_pc_redirect = 16'h0; cm_prdsel = 4'h0; cm_pprdsel = 4'h0;
      repeat (2) @(posedge clk);
      #1 rst_n = 1'b1;

      // idle after reset
      for (int c = 0; c < 5; c++) begin
         to_neg();
         check("idle_deq", 32'(rob_deq), 32'h0);
         check("idle_count", 32'(retire_count), 32'h0);
         check("idle_stall", 32'(fetch_stall), 32'h0);
         check("idle_rrat0", 32'(restore_preg), 32'h0);
         to_pos();
      end

      // ADD R3,R1,R2 retires, prd 9 replaces p3
      head(16'h1642, 16'h0000, 16'h0001, 16'h0001, 4'd9, 4'd3);
      to_neg();
      check("add_deq", 32'(rob_deq), 32'h1);
      check("add_free", 32'(free_valid), 32'h1);
      check("add_fpreg", 32'(free_preg), 32'h3);
      to_pos();
      cm_ready = 1'b0;
      to_neg();
      check("add_count", 32'(retire_count), 32'h1);
      to_pos();

      // BRnzp mispredict at 0x0010
      head(16'h0E0F, 16'h0010, 16'h0011, 16'h0020, 4'd5, 4'd6);
      to_neg();
      check("br_deq", 32'(rob_deq), 32'h1);
      check("br_free", 32'(free_valid), 32'h0);
      to_pos();
      to_neg();
      check("fl_flush", 32'(flush), 32'h1);
      check("fl_rpc", 32'(redirect_pc), 32'h0020);
      check("fl_deq", 32'(rob_deq), 32'h0);
      check("fl_stall", 32'(fetch_stall), 32'h1);
      to_pos();
      head(16'h7000, 16'h0020, 16'h0021, 16'h0021, 4'd0, 4'd0);

      // restore walk, then same-cycle dequeue in RUN
      for (int k = 0; k < 8; k++) begin
         to_neg();
         check("rs_valid", 32'(restore_valid), 32'h1);
         check("rs_areg", 32'(restore_areg), 32'(k));
         check("rs_preg", 32'(restore_preg), (k == 3) ? 32'd9 : 32'(k));
         check("rs_stall", 32'(fetch_stall), 32'h1);
         check("rs_deq", 32'(rob_deq), 32'h0);
         to_pos();
      end
      to_neg();
      check("run_deq", 32'(rob_deq), 32'h1);
      check("run_stall", 32'(fetch_stall), 32'h0);
      to_pos();
      cm_ready = 1'b0;
      to_neg();
      check("run_count", 32'(retire_count), 32'h3);
      to_pos();

      // gwe low freezes everything
      gwe = 1'b0; cm_ready = 1'b1;
      for (int c = 0; c < 3; c++) begin
         to_neg();
         check("gwe_deq", 32'(rob_deq), 32'h0);
         check("gwe_count", 32'(retire_count), 32'h3);
         to_pos();
      end
      gwe = 1'b1;
      head(16'hC805, 16'h0030, 16'h0031, 16'h0036, 4'd0, 4'd0);
      to_neg();
      to_pos();
      cm_ready = 1'b0;
      repeat (5) begin
         to_neg();
         to_pos();
      end
      check("mid_areg", 32'(restore_areg), 32'h4);
      check("mid_valid", 32'(restore_valid), 32'h1);
      rst_n = 1'b0;
      #1;
      check("arst_stall", 32'(fetch_stall), 32'h0);
      check("arst_valid", 32'(restore_valid), 32'h0);
      check("arst_areg", 32'(restore_areg), 32'h0);
      check("arst_count", 32'(retire_count), 32'h0);
      check("arst_rpc", 32'(redirect_pc), 32'h0);
      to_pos();
      rst_n = 1'b1;
      head(16'h7000, 16'h0040, 16'h0041, 16'h0041, 4'd0, 4'd0);
      to_neg();
      check("rel_deq", 32'(rob_deq), 32'h1);
      check("rel_stall", 32'(fetch_stall), 32'h0);
      to_pos();

      // counter wrap: keep retiring non-writing stores
      repeat (65534) @(posedge clk);
      #1;
      to_neg();
      check("wrap_ffff", 32'(retire_count), 32'hFFFF);
      to_pos();
      to_neg();
      check("wrap_zero", 32'(retire_count), 32'h0);
      to_pos();
      cm_ready = 1'b0;

      // JSR mispredict writes R7; walk shows identity except R7
      head(16'h4805, 16'h0040, 16'h0041, 16'h0050, 4'd12, 4'd7);
      to_neg();
      check("jsr_free", 32'(free_valid), 32'h1);
      check("jsr_fpreg", 32'(free_preg), 32'h7);
      to_pos();
      cm_ready = 1'b0;
      to_neg();
      check("jsr_rpc", 32'(redirect_pc), 32'h0050);
      to_pos();
      for (int k = 0; k < 8; k++) begin
         to_neg();
         check("jsr_rs_preg", 32'(restore_preg), (k == 7) ? 32'd12 : 32'(k));
         to_pos();
      end
      repeat (3) to_pos();

      $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
      $finish;
   end
endmodule
